wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between pipeline WB and mul/div unit
module wb_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  starv_q, starv_d;
    logic        err_q;
    logic [4:0]  fifo_rd_q   [2];
    logic [31:0] fifo_data_q [2];

    logic        fifo_nonempty;
    logic        md_acc;
    logic        grant_wb, grant_fifo, grant_pass;
    logic        push, pop;
    logic        wr_idx;
    logic [4:0]  g_rd;
    logic [31:0] g_data;

    assign fifo_nonempty = (count_q != 2'd0);
    assign md_ready      = !rst && (count_q != 2'd2);
    assign md_acc        = md_valid && md_ready;
    assign stall         = (state_q == S_FORCE);
    assign err           = err_q;

    // Pick the single source that owns the write port this cycle.
    always_comb begin
        grant_wb   = 1'b0;
        grant_fifo = 1'b0;
        grant_pass = 1'b0;
        if (!rst) begin
            if (stall) begin
                grant_fifo = fifo_nonempty;
            end else if (wb_valid) begin
                grant_wb = 1'b1;
            end else if (fifo_nonempty) begin
                grant_fifo = 1'b1;
            end else if (md_acc) begin
                grant_pass = 1'b1;
            end
        end
    end

    assign pop  = grant_fifo;
    assign push = md_acc && !grant_pass;
    // A push lands behind whatever survives this cycle's pop.
    assign wr_idx = (count_q == 2'd1) && !pop;

    // Route the granted source onto the write port; r0 writes are suppressed.
    always_comb begin
        g_rd   = 5'd0;
        g_data = 32'd0;
        if (grant_wb) begin
            g_rd   = wb_rd;
            g_data = wb_data;
        end else if (grant_fifo) begin
            g_rd   = fifo_rd_q[0];
            g_data = fifo_data_q[0];
        end else if (grant_pass) begin
            g_rd   = md_rd;
            g_data = md_data;
        end
    end

    assign rf_we    = (grant_wb || grant_fifo || grant_pass) && (g_rd != 5'd0);
    assign rf_waddr = g_rd;
    assign rf_wdata = g_data;

    // Occupancy and starvation bookkeeping for the next cycle.
    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        starv_d = starv_q;
        if (!fifo_nonempty || pop) begin
            starv_d = 2'd0;
        end else if (grant_wb && (starv_q != 2'd3)) begin
            starv_d = starv_q + 2'd1;
        end
    end

    // Next-state logic: FORCE is a one-cycle window that steals the port for the FIFO head.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_d != 2'd0) begin
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (starv_d == 2'd3) begin
                    state_d = S_FORCE;
                end else if (count_d == 2'd0) begin
                    state_d = S_IDLE;
                end
            end
            S_FORCE: begin
                state_d = (count_d == 2'd0) ? S_IDLE : S_PEND;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= 2'd0;
            starv_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            starv_q <= starv_d;
            if (stall && wb_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    // FIFO storage: shift on pop, write at the first free slot on push.
    always_ff @(posedge clk) begin
        if (pop) begin
            fifo_rd_q[0]   <= fifo_rd_q[1];
            fifo_data_q[0] <= fifo_data_q[1];
        end
        if (push) begin
            fifo_rd_q[wr_idx]   <= md_rd;
            fifo_data_q[wr_idx] <= md_data;
        end
    end

endmodule
